// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types, constants and helpers for the UART blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Transmitter frame sequencing states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT   = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } uart_tx_state_t;

    // Parity sense selectors
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Widest supported data field; narrower words are zero-extended
    localparam int MAX_DATA_BITS = 9;

    // Parity over the data word; zero padding does not affect the XOR
    function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data,
                                         input logic                      odd);
        return (^data) ^ odd;
    endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/rise_detect.sv
`default_nettype none
// ============================================================================
// Module      : rise_detect
// Description : One-cycle pulse on each rising edge of a clk-synchronous
//               input (used for divided-clock enables).
// Revision    : 1.0 - initial release
// ============================================================================
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic pulse
);

    logic in_q;

    // Delay the input by one clk so a low-to-high change can be seen
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_q <= 1'b0;
        end else begin
            in_q <= in;
        end
    end

    assign pulse = in & ~in_q;

endmodule : rise_detect
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : UART transmitter, LSB first, optional parity, 1 or 2 stop
//               bits. Bit timing comes from rising edges of baud_clk, which
//               is sampled in the clk domain rather than used as a clock.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud_clk,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done
);

    import uart_pkg::*;

    localparam int IDX_W = 4;

    uart_tx_state_t       state_q,    state_d;
    logic [DATA_BITS-1:0] shift_q,    shift_d;
    logic [IDX_W-1:0]     idx_q,      idx_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 parity_q,   parity_d;
    logic                 tx_q,       tx_d;
    logic                 busy_q,     busy_d;
    logic                 done_q,     done_d;
    logic                 tick;

    rise_detect u_baud_edge (
        .clk   (clk),
        .reset (reset),
        .in    (baud_clk),
        .pulse (tick)
    );

    // State and datapath registers; tx resets high so the line idles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            idx_q      <= '0;
            stop_cnt_q <= 1'b0;
            parity_q   <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            idx_q      <= idx_d;
            stop_cnt_q <= stop_cnt_d;
            parity_q   <= parity_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Frame sequencing: accept in IDLE, every later step waits for a tick
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        idx_d      = idx_q;
        stop_cnt_d = stop_cnt_q;
        parity_d   = parity_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (tx_valid) begin
                    shift_d  = tx_data;
                    parity_d = calc_parity(MAX_DATA_BITS'(tx_data),
                                           (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN);
                    busy_d   = 1'b1;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                // A tick coinciding with accept was seen in IDLE, so the
                // start bit always aligns to a tick strictly after accept
                if (tick) begin
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    tx_d    = shift_q[0];
                    shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
                    idx_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    if (idx_q == IDX_W'(DATA_BITS - 1)) begin
                        stop_cnt_d = 1'b0;
                        if (PARITY_EN != 0) begin
                            tx_d    = parity_q;
                            state_d = PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = STOP;
                        end
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        tx_d    = shift_q[0];
                        shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    tx_d       = 1'b1;
                    stop_cnt_d = 1'b0;
                    state_d    = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign tx_ready = (state_q == IDLE);
    assign tx       = tx_q;
    assign busy     = busy_q;
    assign tx_done  = done_q;

endmodule : uart_tx
`default_nettype wire
